mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 116 +++++++++++
 tb/tb_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one outstanding load/store at a time over
// valid/ready request and response channels, with a programmable access latency.
`timescale 1ns/1ps

module mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  // state  | meaning
  // S_IDLE | ready for a request (req_ready_o asserted one cycle after reset)
  // S_WAIT | latency down-counter running; access executes when it reaches 0
  // S_RESP | response held stable until the core takes it

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [33:0]   SPAN     = 34'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          acc_err;
  logic          exec;
  logic          mem_we;

  // 34-bit compare keeps the range check correct even if the span reaches 4 GiB
  assign offset  = addr_q - BASE_ADDR;
  assign idx     = offset[AW+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                   ({2'b00, offset} >= SPAN) || (we_q && (be_q == 4'b0000));
  assign exec    = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_we  = exec && we_q && !acc_err;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) mem_q[idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            be_q        <= req_be_i;
            cnt_q       <= CNT_LOAD;
            req_ready_o <= 1'b0;
            state_q     <= S_WAIT;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= acc_err;
            rsp_rdata_o <= (!we_q && !acc_err) ? mem_q[idx] : 32'h0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against a word-array reference model.
`timescale 1ns/1ps

module tb_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 4;
  localparam logic [31:0] BASE    = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit model_err(bit we, logic [31:0] addr, logic [3:0] be);
    longint a;
    a = longint'(addr);
    return (a % 4 != 0) || (a < longint'(BASE)) ||
           (a - longint'(BASE) >= longint'(DEPTH) * 4) || (we && be == 4'b0000);
  endfunction

  // Applies the access to the model and returns the expected read data.
  function automatic logic [31:0] model_access(bit we, logic [31:0] addr,
                                               logic [31:0] wdata, logic [3:0] be);
    int w;
    if (model_err(we, addr, be)) return 32'h0;
    w = int'((addr - BASE) / 4);
    if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) model_mem[w][8*k +: 8] = wdata[8*k +: 8];
      return 32'h0;
    end
    return model_mem[w];
  endfunction

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata,
                        output logic err, output int lat);
    int guard;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wdata; req_be_i = be;
    guard = 0;
    while (req_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required=1", req_ready_o);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 0;
    while (rsp_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk_i); #1;
      lat++;
    end
    checks++;
    if (lat >= 50) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required=1", rsp_valid_o);
    end
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b000 || rsp_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h required 0/0/0/0",
               req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got=%b required=0", req_ready_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got=%b required=1", req_ready_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
    void'(model_access(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111));
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != LATENCY) begin
      errors++;
      $display("FAIL basic_store: rdata=%h err=%b lat=%0d required 0/0/%0d", rd, er, lat, LATENCY);
    end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != LATENCY) begin
      errors++;
      $display("FAIL basic_load: rdata=%h err=%b lat=%0d required deadbeef/0/%0d", rd, er, lat, LATENCY);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010, rd, er, lat);
    void'(model_access(1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010));
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin
      errors++;
      $display("FAIL partial_store: rdata=%h err=%b required deadaaef/0", rd, er);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b0, 32'h8000_0011, 32'h0, 4'b1111, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_load: rdata=%h err=%b required 0/1", rd, er);
    end
    do_txn(1'b1, 32'h8000_0012, 32'h1234_5678, 4'b1111, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store: err=%b required 1", er);
    end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_write: rdata=%h err=%b required deadaaef/0", rd, er);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [4];
    logic        wes   [4];
    logic [3:0]  bes   [4];
    logic        exp   [4];
    addrs = '{32'h8000_0FFC, 32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0000};
    wes   = '{1'b0, 1'b0, 1'b0, 1'b1};
    bes   = '{4'hF, 4'hF, 4'hF, 4'h0};
    exp   = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_txn(wes[i], addrs[i], 32'h5555_AAAA, bes[i], rd, er, lat);
      checks++;
      if (er !== exp[i]) begin
        errors++;
        $display("FAIL bounds_err[%0d] addr=%h: err=%b required %b", i, addrs[i], er, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h8000_0010; req_be_i = 4'hF;
    rsp_ready_i = 1'b0;
    @(posedge clk_i); #1;
    req_we_i = 1'b1; req_addr_i = 32'h8000_0014; req_wdata_i = 32'h1111_2222;
    guard = 0;
    while (rsp_valid_o !== 1'b1 && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL bp_rsp_timeout: rsp_valid=%b required=1", rsp_valid_o);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_AAEF || rsp_err_o !== 1'b0 ||
          req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b ready=%b required 1/deadaaef/0/0",
                 c, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid_o, req_ready_o);
    end
    for (int c = 0; c < LATENCY + 2; c++) begin
      @(posedge clk_i); #1;
      checks++;
      if (rsp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_no_second_accept[%0d]: valid=%b required 0", c, rsp_valid_o);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h8000_0010;
    req_wdata_i = 32'hCAFE_F00D; req_be_i = 4'hF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: valid=%b ready=%b required 0/0", rsp_valid_o, req_ready_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    for (int c = 0; c < LATENCY + 2; c++) begin
      @(posedge clk_i); #1;
      checks++;
      if (rsp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_rsp[%0d]: valid=%b required 0", c, rsp_valid_o);
      end
    end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_store_dropped: rdata=%h err=%b required deadaaef/0", rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wdata;
    logic [3:0]  be;
    logic        er, we;
    bit          exp_er;
    int          lat, sel;
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom;
      addr  = BASE + 32'(w) * 4;
      do_txn(1'b1, addr, wdata, 4'hF, rd, er, lat);
      void'(model_access(1'b1, addr, wdata, 4'hF));
    end
    for (int i = 0; i < 60; i++) begin
      sel   = int'($urandom_range(0, 9));
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if (sel < 7)       addr = BASE + 32'($urandom_range(0, 15)) * 4;
      else if (sel == 7) addr = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = BASE + DEPTH * 4 + 32'($urandom_range(0, 7)) * 4;
      else               addr = BASE - 32'($urandom_range(1, 8)) * 4;
      exp_er = model_err(we, addr, be);
      exp_rd = model_access(we, addr, wdata, be);
      do_txn(we, addr, wdata, be, rd, er, lat);
      checks++;
      if (rd !== exp_rd || er !== exp_er || lat != LATENCY) begin
        errors++;
        $display("FAIL random[%0d] we=%b addr=%h be=%b: rdata=%h err=%b lat=%0d required %h/%b/%0d",
                 i, we, addr, be, rd, er, lat, exp_rd, exp_er, LATENCY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_store();
    test_misaligned();
    test_bounds();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
